// File: rtl/thr_frame_tx.sv
// -----------------------------------------------------------------------------
// thr_frame_tx
//
// Sends one 11-byte result frame to a byte-wide UART transmitter each time a
// start request is accepted:
//   HEADER, scan_id, cnt[63:56] ... cnt[7:0], checksum
// The checksum is the XOR of the nine payload bytes (HEADER excluded) and is
// always derived from the values latched at start, never from live inputs.
// Each byte waits for the transmitter's done pulse; if it does not arrive
// within TIMEOUT_CYC cycles the frame is aborted with an error pulse.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   i_start       one-cycle request to send a frame (honoured only while idle)
//   i_scan_id     scan/threshold id echoed in the frame
//   i_cnt_Thr     64-bit threshold-crossing count
//   o_Tx_Done     UART byte-finished pulse (input; name follows the UART core)
//   i_Tx_DV       byte-valid strobe to the UART (output; name follows the UART)
//   i_Tx_Byte     byte presented to the UART, held between strobes
//   o_busy        frame in progress
//   o_frame_done  one-cycle pulse, frame fully sent
//   o_err         one-cycle pulse, frame aborted on timeout
// -----------------------------------------------------------------------------
module thr_frame_tx #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter logic [31:0] TIMEOUT_CYC = 32'd2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_scan_id,
  input  logic [63:0] i_cnt_Thr,
  input  logic        o_Tx_Done,
  output logic        i_Tx_DV,
  output logic [7:0]  i_Tx_Byte,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_err
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  localparam logic [3:0]  LAST_IDX = 4'd10;
  localparam logic [31:0] TMO_LAST = TIMEOUT_CYC - 32'd1;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  scan_q, scan_d;
  logic [63:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;

  // Frame byte at position idx, built from the latched payload.
  function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                            input logic [7:0]  scan,
                                            input logic [63:0] cnt);
    logic [7:0] csum;
    logic [3:0] sel;
    csum = scan;
    for (int i = 0; i < 8; i++) csum ^= cnt[8*i +: 8];
    sel = 4'd9 - idx;  // idx 2 -> most significant count byte
    case (idx)
      4'd0:    frame_byte = HEADER;
      4'd1:    frame_byte = scan;
      4'd10:   frame_byte = csum;
      default: frame_byte = cnt[{sel[2:0], 3'b000} +: 8];
    endcase
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    scan_d  = scan_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    o_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          scan_d  = i_scan_id;
          cnt_d   = i_cnt_Thr;
          idx_d   = 4'd0;
          byte_d  = HEADER;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        tmo_d   = 32'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A done pulse takes priority over a timeout expiring in the same cycle.
        if (o_Tx_Done) begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 4'd1;
            byte_d  = frame_byte(idx_q + 4'd1, scan_q, cnt_q);
            state_d = S_SEND;
          end else begin
            state_d = S_DONE;
          end
        end else if (tmo_q >= TMO_LAST) begin
          o_err   = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 32'd1;  // saturating
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      tmo_q   <= 32'd0;
      scan_q  <= 8'h00;
      cnt_q   <= 64'd0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      scan_q  <= scan_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
    end
  end

  assign i_Tx_DV      = (state_q == S_SEND);
  assign i_Tx_Byte    = byte_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_thr_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_thr_frame_tx
//
// Self-checking bench for thr_frame_tx. A transaction-level reference model
// (frame contents from the byte-order/XOR rules, timing from cycle stamps of
// strobes and done pulses) predicts every output each cycle; a compare process
// checks the DUT on the falling edge. Directed scenarios pin the model with
// literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_thr_frame_tx;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_scan_id = 8'h00;
  logic [63:0] i_cnt_Thr = 64'd0;
  logic        resp_done = 1'b0;
  logic        spur_done = 1'b0;
  logic        o_Tx_Done;
  logic        i_Tx_DV;
  logic [7:0]  i_Tx_Byte;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_err;

  assign o_Tx_Done = resp_done | spur_done;

  thr_frame_tx #(
    .HEADER      (8'hA5),
    .TIMEOUT_CYC (32'(TMO))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_scan_id    (i_scan_id),
    .i_cnt_Thr    (i_cnt_Thr),
    .o_Tx_Done    (o_Tx_Done),
    .i_Tx_DV      (i_Tx_DV),
    .i_Tx_Byte    (i_Tx_Byte),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xsum(input logic [7:0] s, input logic [63:0] c);
    logic [7:0] x;
    x = s;
    for (int k = 0; k < 8; k++) x ^= c[8*k +: 8];
    return x;
  endfunction

  logic       m_busy = 1'b0, m_dv = 1'b0, m_fd = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_sent = 0;          // bytes strobed so far in this frame
  longint     m_cyc = 0;           // index of the current cycle
  longint     m_dv_cyc = 0;        // cycle of the latest strobe
  logic [7:0] m_frame [11];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_dv <= 1'b0; m_fd <= 1'b0; m_byte <= 8'h00;
      m_sent <= 0; m_cyc <= 0; m_dv_cyc <= 0;
    end else begin
      if (!m_busy) begin
        if (i_start) begin
          m_frame[0] <= 8'hA5;
          m_frame[1] <= i_scan_id;
          for (int k = 0; k < 8; k++) m_frame[2+k] <= i_cnt_Thr[63-8*k -: 8];
          m_frame[10] <= xsum(i_scan_id, i_cnt_Thr);
          m_busy <= 1'b1; m_dv <= 1'b1; m_sent <= 1; m_byte <= 8'hA5;
          m_dv_cyc <= m_cyc + 1;
        end
      end else if (m_fd) begin
        m_fd <= 1'b0; m_busy <= 1'b0;
      end else if (m_dv) begin
        m_dv <= 1'b0;
      end else if (o_Tx_Done) begin
        if (m_sent == 11) m_fd <= 1'b1;
        else begin
          m_byte <= m_frame[m_sent]; m_sent <= m_sent + 1;
          m_dv <= 1'b1; m_dv_cyc <= m_cyc + 1;
        end
      end else if (m_cyc - m_dv_cyc == longint'(TMO)) begin
        m_busy <= 1'b0;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process + monitor
  // ---------------------------------------------------------------------------
  int         tb_cyc = 0;
  int         fd_n = 0, err_n = 0, err_cyc = 0;
  logic [7:0] cap_q [$];
  int         dv_cyc_q [$];

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      check("dv",         64'(i_Tx_DV),      64'(m_dv));
      check("byte",       64'(i_Tx_Byte),    64'(m_byte));
      check("busy",       64'(o_busy),       64'(m_busy));
      check("frame_done", 64'(o_frame_done), 64'(m_fd));
      check("err",        64'(o_err),
            64'(m_busy && !m_dv && !m_fd && (m_cyc - m_dv_cyc == longint'(TMO)) && !o_Tx_Done));
      if (i_Tx_DV) begin
        cap_q.push_back(i_Tx_Byte);
        dv_cyc_q.push_back(tb_cyc);
      end
      if (o_frame_done) fd_n <= fd_n + 1;
      if (o_err) begin
        err_n   <= err_n + 1;
        err_cyc <= tb_cyc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // UART responder: answers each strobe after a delay, optionally dropping one
  // ---------------------------------------------------------------------------
  int resp_fixed = 5;   // 0 selects a random delay 1..6
  int resp_total = 0;   // strobes seen since time zero
  int drop_at    = 0;   // absolute strobe number left unanswered, 0 = none

  initial begin
    forever begin
      @(negedge clk);
      if (rst && i_Tx_DV) begin
        int d;
        resp_total++;
        if (drop_at == 0 || resp_total != drop_at) begin
          d = (resp_fixed != 0) ? resp_fixed : int'($urandom_range(1, 6));
          repeat (d) @(posedge clk);
          #1 resp_done = 1'b1;
          @(posedge clk);
          #1 resp_done = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic [7:0] nom_exp [11] = '{8'hA5, 8'h3C, 8'h01, 8'h23, 8'h45, 8'h67,
                               8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h3C};

  task automatic send_start(input logic [7:0] s, input logic [63:0] c);
    @(posedge clk);
    #1 i_scan_id = s; i_cnt_Thr = c; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    i_scan_id = ~s;          // live inputs move; frame must use latched data
    i_cnt_Thr = ~c;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_end_bound", 64'(o_busy), 64'd0);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n = 0;
    while (cap_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("byte_wait_bound", 64'(cap_q.size() >= target), 64'd1);
  endtask

  task automatic check_nominal(input int base);
    check("nom_dv_count", 64'(cap_q.size() - base), 64'd11);
    for (int k = 0; k < 11; k++)
      if (base + k < cap_q.size()) check("nom_byte", 64'(cap_q[base+k]), 64'(nom_exp[k]));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int base, fdb, errb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dv",   64'(i_Tx_DV),      64'd0);
    check("rst_byte", 64'(i_Tx_Byte),    64'd0);
    check("rst_busy", 64'(o_busy),       64'd0);
    check("rst_fd",   64'(o_frame_done), 64'd0);
    check("rst_err",  64'(o_err),        64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal frame, done 5 cycles after each strobe
    resp_fixed = 5;
    base = cap_q.size(); fdb = fd_n;
    send_start(8'h3C, 64'h0123_4567_89AB_CDEF);
    wait_idle(400);
    check_nominal(base);
    check("nom_checksum", 64'(cap_q[base+10]), 64'h3C);
    check("nom_dv_spacing", 64'(dv_cyc_q[base+1] - dv_cyc_q[base]), 64'd6);
    check("nom_fd_count", 64'(fd_n - fdb), 64'd1);

    // Zero count
    base = cap_q.size(); fdb = fd_n;
    send_start(8'h00, 64'd0);
    wait_idle(400);
    check("zero_dv_count", 64'(cap_q.size() - base), 64'd11);
    check("zero_header", 64'(cap_q[base]), 64'hA5);
    for (int k = 1; k < 11; k++) check("zero_byte", 64'(cap_q[base+k]), 64'd0);
    check("zero_fd_count", 64'(fd_n - fdb), 64'd1);

    // Timeout after the third byte
    base = cap_q.size(); fdb = fd_n; errb = err_n;
    drop_at = resp_total + 3;
    send_start(8'h5A, 64'hFEDC_BA98_7654_3210);
    wait_idle(200);
    repeat (20) @(negedge clk);
    check("tmo_dv_count", 64'(cap_q.size() - base), 64'd3);
    check("tmo_err_count", 64'(err_n - errb), 64'd1);
    check("tmo_err_delay", 64'(err_cyc - dv_cyc_q[base+2]), 64'(TMO));
    check("tmo_no_fd", 64'(fd_n - fdb), 64'd0);
    check("tmo_busy", 64'(o_busy), 64'd0);
    drop_at = 0;

    // Done arriving on the final timeout cycle
    resp_fixed = TMO;
    base = cap_q.size(); fdb = fd_n; errb = err_n;
    send_start(8'h11, 64'h1122_3344_5566_7788);
    wait_idle(600);
    check("col_dv_count", 64'(cap_q.size() - base), 64'd11);
    check("col_err_count", 64'(err_n - errb), 64'd0);
    check("col_fd_count", 64'(fd_n - fdb), 64'd1);

    // Restart request while busy is ignored
    resp_fixed = 3;
    base = cap_q.size(); fdb = fd_n;
    send_start(8'h3C, 64'h0123_4567_89AB_CDEF);
    wait_bytes(base + 5, 200);
    @(posedge clk);
    #1 i_scan_id = 8'hC3; i_cnt_Thr = 64'hDEAD_BEEF_0BAD_F00D; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    wait_idle(400);
    check_nominal(base);
    check("restart_fd_count", 64'(fd_n - fdb), 64'd1);

    // Reset during byte 7
    base = cap_q.size();
    send_start(8'h77, 64'h0F0F_F0F0_1234_ABCD);
    wait_bytes(base + 7, 200);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_dv",   64'(i_Tx_DV),      64'd0);
    check("mid_rst_byte", 64'(i_Tx_Byte),    64'd0);
    check("mid_rst_busy", 64'(o_busy),       64'd0);
    check("mid_rst_fd",   64'(o_frame_done), 64'd0);
    check("mid_rst_err",  64'(o_err),        64'd0);
    fdb = fd_n; errb = err_n;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_no_fd",  64'(fd_n - fdb),  64'd0);
    check("post_rst_no_err", 64'(err_n - errb), 64'd0);
    check("post_rst_idle",   64'(o_busy),       64'd0);
    base = cap_q.size();
    send_start(8'h42, 64'h0000_0000_0000_0042);
    wait_idle(400);
    check("fresh_dv_count", 64'(cap_q.size() - base), 64'd11);
    check("fresh_fd_count", 64'(fd_n - fdb), 64'd1);
    check("fresh_checksum", 64'(cap_q[base+10]), 64'h00);

    // Randomized frames
    resp_fixed = 0;
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 3) == 0) drop_at = resp_total + int'($urandom_range(1, 11));
      send_start(8'($urandom), {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 60)) @(posedge clk);
        #1 i_scan_id = 8'($urandom); i_cnt_Thr = {$urandom, $urandom}; i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
      end
      wait_idle(800);
      drop_at = 0;
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1 spur_done = 1'b1;
      @(posedge clk);
      #1 spur_done = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/thr_frame_tx.md
THR_FRAME_TX -- requirements
Module: thr_frame_tx

Interface
REQ-001 Parameter HEADER, default 8'hA5: first byte of every frame.
REQ-002 Parameter TIMEOUT_CYC, default 32'd2_000_000: maximum clk cycles to wait for o_Tx_Done per byte.
REQ-003 clk  input  1: single clock; all logic rising-edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 i_start  input  1: one-cycle request to send a result frame.
REQ-006 i_scan_id  input  8: threshold/scan byte echoed in the frame.
REQ-007 i_cnt_Thr  input  64: threshold-crossing count to report.
REQ-008 o_Tx_Done  input  1: UART transmitter one-cycle pulse, byte finished.
REQ-009 i_Tx_DV  output  1: one-cycle strobe to the UART transmitter, byte valid.
REQ-010 i_Tx_Byte  output  8: byte presented to the UART transmitter.
REQ-011 o_busy  output  1: high from start acceptance until the frame ends or aborts.
REQ-012 o_frame_done  output  1: one-cycle pulse, frame completely sent.
REQ-013 o_err  output  1: one-cycle pulse, frame aborted on timeout.

Function
REQ-014 Frame is 11 bytes, in order: HEADER, scan_id, cnt[63:56], cnt[55:48], ... cnt[7:0], checksum.
REQ-015 Checksum is the bitwise XOR of bytes 2..10 (scan_id and the 8 count bytes); HEADER is excluded.
REQ-016 States are IDLE, SEND, WAIT, DONE.
REQ-017 IDLE: when i_start=1, latch i_scan_id and i_cnt_Thr, clear the byte index to 0, set o_busy=1, and go to SEND.
REQ-018 SEND: drive i_Tx_Byte with the frame byte at the current index, assert i_Tx_DV for exactly this one cycle, clear the timeout counter, and go to WAIT.
REQ-019 i_Tx_DV rises in the cycle immediately after the cycle in which i_start is sampled high.
REQ-020 i_Tx_Byte holds its value from SEND until the next SEND or until reset.
REQ-021 WAIT, o_Tx_Done=1, index<10: increment the index and go to SEND, so the next i_Tx_DV occurs one cycle after o_Tx_Done is sampled.
REQ-022 WAIT, o_Tx_Done=1, index=10: go to DONE.
REQ-023 DONE: pulse o_frame_done for one cycle, clear o_busy, and return to IDLE.
REQ-024 WAIT: the timeout counter increments each cycle; on reaching TIMEOUT_CYC-1 without o_Tx_Done, pulse o_err, clear o_busy, and return to IDLE with no further i_Tx_DV.
REQ-025 If o_Tx_Done and timeout expiry occur in the same cycle, o_Tx_Done wins and o_err is not pulsed.
REQ-026 i_start while o_busy=1 is ignored; the latched data stays unchanged.
REQ-027 o_Tx_Done outside WAIT is ignored.
REQ-028 i_start in the same cycle as o_frame_done is ignored; a new frame needs i_start while IDLE.
REQ-029 Checksum is computed from the latched values only, never from live inputs.
REQ-030 The byte index is 4 bits and never exceeds 10.
REQ-031 The timeout counter is 32 bits and saturates rather than wrapping.

Reset
REQ-032 On rst=0, asynchronously: state=IDLE, i_Tx_DV=0, i_Tx_Byte=8'h00, o_busy=0, o_frame_done=0, o_err=0, index=0, timeout counter=0, latches=0.
REQ-033 Reset asserted mid-frame abandons the frame; after release the block waits in IDLE for a new i_start, with no o_err or o_frame_done pulse.

Verification
REQ-034 Nominal frame: scan_id=8'h3C, cnt=64'h0123_4567_89AB_CDEF, Tx_Done 5 cycles after each DV -> bytes A5,3C,01,23,45,67,89,AB,CD,EF,checksum; checksum = 3C^01^23^45^67^89^AB^CD^EF; exactly 11 DV pulses; one o_frame_done.
REQ-035 Zero count: scan_id=8'h00, cnt=0 -> bytes A5 followed by ten 00 bytes (checksum 00); o_busy high from the cycle after i_start to the cycle of o_frame_done.
REQ-036 Timeout: TIMEOUT_CYC=16, no Tx_Done after the 3rd byte -> o_err pulse 16 cycles after the 3rd DV; o_busy=0; no 4th DV.
REQ-037 Collision: Tx_Done arrives exactly on the final timeout cycle -> no o_err; the next byte is sent.
REQ-038 Re-start while busy: i_start pulsed during byte 5 with different data -> frame continues with the original data; no restart.
REQ-039 Mid-frame reset: rst low during byte 7 -> all outputs 0 immediately; a following i_start sends a complete, fresh 11-byte frame.
